// File: rtl/lvt_read_select.sv
// rtl/lvt_read_select.sv - live-value-table read selection for the multiported data cache
//
// Tracks which write port last wrote each word address. Each read port gets the
// live word from the banks' read data, with a fixed 2-cycle latency.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   wr_en       per-write-port strobe [NUM_WR]
//   wr_addr     per-write-port word address, port p at [p*ADDR_W +: ADDR_W]
//   rd_en       per-read-port request [NUM_RD]
//   rd_addr     per-read-port word address, same packing as wr_addr
//   bank_rdata  bank read data, read port r / bank b at [(r*NUM_WR+b)*WORD_W +: WORD_W]
//   rd_data     registered live word per read port
//   rd_valid    rd_data valid strobe per read port
//   rd_sel      bank index chosen for each read port
module lvt_read_select #(
   parameter int NUM_WR = 4,
   parameter int NUM_RD = 4,
   parameter int ADDR_W = 6,
   parameter int WORD_W = 32,
   localparam int SEL_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_WR-1:0]                wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]         wr_addr,
   input  logic [NUM_RD-1:0]                rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]         rd_addr,
   input  logic [NUM_RD*NUM_WR*WORD_W-1:0]  bank_rdata,
   output logic [NUM_RD*WORD_W-1:0]         rd_data,
   output logic [NUM_RD-1:0]                rd_valid,
   output logic [NUM_RD*SEL_W-1:0]          rd_sel
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [SEL_W-1:0]  lvt      [DEPTH];
   logic [NUM_RD-1:0] s1_valid;
   logic [SEL_W-1:0]  s1_sel   [NUM_RD];
   logic [WORD_W-1:0] mux_data [NUM_RD];

   // Ports are visited in ascending order, so on an address collision the
   // highest-indexed port's assignment is the one that lands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            lvt[i] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
               lvt[wr_addr[p*ADDR_W +: ADDR_W]] <= SEL_W'(p);
            end
         end
      end
   end

   // The LVT read samples the pre-write entry on a same-cycle collision,
   // which lines up with the banks returning old data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= '0;
         for (int r = 0; r < NUM_RD; r++) begin
            s1_sel[r] <= '0;
         end
      end else begin
         s1_valid <= rd_en;
         for (int r = 0; r < NUM_RD; r++) begin
            if (rd_en[r]) begin
               s1_sel[r] <= lvt[rd_addr[r*ADDR_W +: ADDR_W]];
            end
         end
      end
   end

   // A selection that matches no bank (only possible for non power-of-two
   // NUM_WR) falls through to zero data.
   always_comb begin
      for (int r = 0; r < NUM_RD; r++) begin
         mux_data[r] = '0;
         for (int b = 0; b < NUM_WR; b++) begin
            if (s1_sel[r] == SEL_W'(b)) begin
               mux_data[r] = bank_rdata[(r*NUM_WR+b)*WORD_W +: WORD_W];
            end
         end
      end
   end

   // Data and selection hold their last values while no request is in stage 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= '0;
         rd_sel   <= '0;
      end else begin
         rd_valid <= s1_valid;
         for (int r = 0; r < NUM_RD; r++) begin
            if (s1_valid[r]) begin
               rd_data[r*WORD_W +: WORD_W] <= mux_data[r];
               rd_sel[r*SEL_W +: SEL_W]    <= s1_sel[r];
            end
         end
      end
   end

endmodule

// File: tb/tb_lvt_read_select.sv
// tb/tb_lvt_read_select.sv - self-checking bench for lvt_read_select
module tb_lvt_read_select;

   localparam int NUM_WR = 4;
   localparam int NUM_RD = 4;
   localparam int ADDR_W = 6;
   localparam int WORD_W = 32;
   localparam int SEL_W  = 2;
   localparam int DEPTH  = 64;

   logic                             clk = 1'b0;
   logic                             reset_n;
   logic [NUM_WR-1:0]                wr_en;
   logic [NUM_WR*ADDR_W-1:0]         wr_addr;
   logic [NUM_RD-1:0]                rd_en;
   logic [NUM_RD*ADDR_W-1:0]         rd_addr;
   logic [NUM_RD*NUM_WR*WORD_W-1:0]  bank_rdata;
   logic [NUM_RD*WORD_W-1:0]         rd_data;
   logic [NUM_RD-1:0]                rd_valid;
   logic [NUM_RD*SEL_W-1:0]          rd_sel;

   lvt_read_select #(
      .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .WORD_W(WORD_W)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .wr_en(wr_en), .wr_addr(wr_addr),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .bank_rdata(bank_rdata),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_sel(rd_sel)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Stimulus as plain per-port values, packed onto the DUT pins by step().
   bit          t_wr_en   [NUM_WR];
   int          t_wr_addr [NUM_WR];
   bit          t_rd_en   [NUM_RD];
   int          t_rd_addr [NUM_RD];
   logic [31:0] bank_word [NUM_RD][NUM_WR];

   // Reference model: owner of every address, plus the read issued last cycle.
   int          owner      [DEPTH];
   bit          prev_en    [NUM_RD];
   int          prev_owner [NUM_RD];
   bit          exp_valid  [NUM_RD];
   int          exp_sel    [NUM_RD];
   logic [31:0] exp_data   [NUM_RD];

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      for (int p = 0; p < NUM_WR; p++) t_wr_en[p] = 1'b0;
      for (int r = 0; r < NUM_RD; r++) t_rd_en[r] = 1'b0;
   endtask

   task automatic pack();
      for (int p = 0; p < NUM_WR; p++) begin
         wr_en[p] = t_wr_en[p];
         wr_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(t_wr_addr[p]);
      end
      for (int r = 0; r < NUM_RD; r++) begin
         rd_en[r] = t_rd_en[r];
         rd_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(t_rd_addr[r]);
         for (int b = 0; b < NUM_WR; b++)
            bank_rdata[(r*NUM_WR+b)*WORD_W +: WORD_W] = bank_word[r][b];
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < DEPTH; a++) owner[a] = 0;
      for (int r = 0; r < NUM_RD; r++) begin
         prev_en[r] = 0; prev_owner[r] = 0;
         exp_valid[r] = 0; exp_sel[r] = 0; exp_data[r] = '0;
      end
   endtask

   task automatic check_outputs();
      for (int r = 0; r < NUM_RD; r++) begin
         check($sformatf("valid%0d", r), 64'(rd_valid[r]), 64'(exp_valid[r]));
         check($sformatf("sel%0d", r), 64'(rd_sel[r*SEL_W +: SEL_W]), 64'(exp_sel[r]));
         check($sformatf("data%0d", r), 64'(rd_data[r*WORD_W +: WORD_W]), 64'(exp_data[r]));
      end
   endtask

   // One clock: a read issued last cycle resolves against this cycle's bank
   // words; this cycle's reads see ownership before this cycle's writes.
   task automatic step();
      int cur_owner [NUM_RD];
      pack();
      for (int r = 0; r < NUM_RD; r++) begin
         cur_owner[r] = owner[t_rd_addr[r]];
         if (prev_en[r]) begin
            exp_valid[r] = 1;
            exp_sel[r]   = prev_owner[r];
            exp_data[r]  = bank_word[r][prev_owner[r]];
         end else begin
            exp_valid[r] = 0;
         end
      end
      if (reset_n) begin
         for (int p = 0; p < NUM_WR; p++)
            if (t_wr_en[p]) owner[t_wr_addr[p]] = p;
      end
      @(posedge clk); #1;
      check_outputs();
      for (int r = 0; r < NUM_RD; r++) begin
         prev_en[r]    = t_rd_en[r] && reset_n;
         prev_owner[r] = cur_owner[r];
      end
   endtask

   initial begin
      reset_n = 1'b0;
      for (int p = 0; p < NUM_WR; p++) t_wr_addr[p] = 0;
      for (int r = 0; r < NUM_RD; r++) begin
         t_rd_addr[r] = 0;
         for (int b = 0; b < NUM_WR; b++) bank_word[r][b] = '0;
      end
      idle();
      model_reset();
      pack();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset_n = 1'b1;

      // Fresh LVT: bank 0 owns address 5.
      bank_word[0][0] = 32'hAAAA0000;
      bank_word[0][1] = 32'hBBBB0001;
      t_rd_en[0] = 1; t_rd_addr[0] = 5;
      step();
      idle();
      step();
      check("reset_owner_sel", 64'(rd_sel[1:0]), 64'd0);
      check("reset_owner_data", 64'(rd_data[31:0]), 64'hAAAA0000);

      // Write on port 2 is visible to a read one cycle later.
      t_wr_en[2] = 1; t_wr_addr[2] = 5;
      step();
      idle();
      bank_word[1][2] = 32'h22222222;
      t_rd_en[1] = 1; t_rd_addr[1] = 5;
      step();
      idle();
      step();
      check("wr_then_rd_sel", 64'(rd_sel[3:2]), 64'd2);
      check("wr_then_rd_data", 64'(rd_data[63:32]), 64'h22222222);

      // Same-cycle write/read returns the previous owner.
      t_wr_en[1] = 1; t_wr_addr[1] = 9;
      step();
      idle();
      t_wr_en[3] = 1; t_wr_addr[3] = 9;
      t_rd_en[0] = 1; t_rd_addr[0] = 9;
      step();
      idle();
      t_rd_en[0] = 1; t_rd_addr[0] = 9;
      step();
      idle();
      check("rdw_old_owner", 64'(rd_sel[1:0]), 64'd1);
      step();
      check("rdw_new_owner", 64'(rd_sel[1:0]), 64'd3);

      // Collision: highest-indexed port wins.
      t_wr_en[1] = 1; t_wr_addr[1] = 12;
      t_wr_en[3] = 1; t_wr_addr[3] = 12;
      step();
      idle();
      t_rd_en[2] = 1; t_rd_addr[2] = 12;
      step();
      idle();
      step();
      check("collision_sel", 64'(rd_sel[5:4]), 64'd3);

      // Random: all ports read distinct addresses every cycle with random writes.
      for (int n = 0; n < 300; n++) begin
         int base;
         base = $urandom_range(0, DEPTH - 1);
         for (int r = 0; r < NUM_RD; r++) begin
            t_rd_en[r] = 1;
            t_rd_addr[r] = (base + r * 16) % DEPTH;
            for (int b = 0; b < NUM_WR; b++) bank_word[r][b] = $urandom;
         end
         for (int p = 0; p < NUM_WR; p++) begin
            t_wr_en[p] = ($urandom_range(0, 1) == 1);
            t_wr_addr[p] = $urandom_range(0, DEPTH - 1);
         end
         step();
      end
      idle();
      step();
      step();

      // Reset while a read is in flight drops it and restores bank 0 ownership.
      t_wr_en[2] = 1; t_wr_addr[2] = 20;
      step();
      idle();
      t_rd_en[0] = 1; t_rd_addr[0] = 20;
      step();
      idle();
      reset_n = 1'b0;
      model_reset();
      #1;
      check("rst_valid", 64'(rd_valid), 64'd0);
      check("rst_sel", 64'(rd_sel), 64'd0);
      check("rst_data", 64'(rd_data != '0), 64'd0);
      step();
      step();
      reset_n = 1'b1;
      t_rd_en[0] = 1; t_rd_addr[0] = 20;
      bank_word[0][0] = 32'h0000B0B0;
      bank_word[0][2] = 32'h2222B0B0;
      step();
      idle();
      step();
      check("post_rst_valid", 64'(rd_valid[0]), 64'd1);
      check("post_rst_sel", 64'(rd_sel[1:0]), 64'd0);
      check("post_rst_data", 64'(rd_data[31:0]), 64'h0000B0B0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
